load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_data_align.sv | 40 ++++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states
// and the alignment predicate used when LSU_ALIGN_CHECK_EN is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } lsu_state_e;

    // True when an access of the given size is not naturally aligned.
    function automatic logic is_misaligned(lsu_size_e size, logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SizeHalf: mis = addr_lo[0];
            SizeWord: mis = (addr_lo != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path of the load/store unit: merges store data into the
// previously read word and extracts/extends load data from the read buffer.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_buf,
    input  logic [31:0] wdata,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic byte_sign;
    logic half_sign;

    assign byte_sign = ~is_unsigned & rd_buf[7];
    assign half_sign = ~is_unsigned & rd_buf[15];

    // Sub-word stores keep the untouched upper bytes of the read buffer.
    always_comb begin
        store_data = wdata;
        load_data  = rd_buf;
        case (size)
            SizeByte: begin
                store_data = {rd_buf[31:8], wdata[7:0]};
                load_data  = {{24{byte_sign}}, rd_buf[7:0]};
            end
            SizeHalf: begin
                store_data = {rd_buf[31:16], wdata[15:0]};
                load_data  = {{16{half_sign}}, rd_buf[15:0]};
            end
            default: begin
                store_data = wdata;
                load_data  = rd_buf;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time, performs a
// read-modify-write for sub-word stores and returns one response per request.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_err=1 and no memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    lsu_size_e         size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rbuf_q, rbuf_d;

    lsu_size_e   req_size_e;
    logic        accept;
    logic        reject;
    logic [31:0] load_data;

    assign req_size_e = lsu_size_e'(req_size);
    assign accept     = req_valid && (state_q == StIdle);

    // Decide whether an incoming request is rejected without memory access.
    always_comb begin
        reject = (req_size_e == SizeRsvd);
`ifdef LSU_ALIGN_CHECK_EN
        reject = reject | is_misaligned(req_size_e, req_addr[1:0]);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (reject) begin
                        state_d = StResp;
                    end else if (req_we && (req_size_e == SizeWord)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = we_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  state_d = resp_ready ? StIdle : StResp;
            default: state_d = StIdle;
        endcase
    end

    // Request capture and read buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= SizeByte;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Capture the request on acceptance; latch memory data while reading.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rbuf_d  = rbuf_q;
        if (accept) begin
            addr_d  = req_addr;
            size_d  = req_size_e;
            we_d    = req_we;
            uns_d   = req_unsigned;
            wdata_d = req_wdata;
            err_d   = reject;
        end
        if (state_q == StRead) begin
            rbuf_d = mem_rdata;
        end
    end

    lsu_data_align u_data_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .rd_buf      (rbuf_q),
        .wdata       (wdata_q),
        .store_data  (mem_wdata),
        .load_data   (load_data)
    );

    // FSM outputs; response data is forced to zero for stores and rejects.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        mem_we     = (state_q == StWrite);
        mem_addr   = addr_q;
        resp_err   = resp_valid & err_q;
        resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a 1 KiB byte RAM model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    logic fill;

    logic [7:0] ram [0:1023];
    logic [9:0] ma;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_pulses;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    assign ma        = mem_addr[9:0];
    assign mem_rdata = {ram[ma + 10'd3], ram[ma + 10'd2], ram[ma + 10'd1], ram[ma]};

    // RAM model: fill with 0xAA on request, otherwise little-endian word writes.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'hAA;
        end else if (mem_we) begin
            ram[ma]         <= mem_wdata[7:0];
            ram[ma + 10'd1] <= mem_wdata[15:8];
            ram[ma + 10'd2] <= mem_wdata[23:16];
            ram[ma + 10'd3] <= mem_wdata[31:24];
            we_cnt          <= we_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a + 3], ram[a + 2], ram[a + 1], ram[a]};
    endfunction

    // Issue one request, then check the response popped from the scoreboard.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_we, input int stall);
        exp_t e;
        int   lat;
        int   we0;
        e = '{tag: tag, rdata: exp_rdata, err: exp_err, lat: exp_lat, we_pulses: exp_we};
        sb.push_back(e);
        check_eq({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        we0          = we_cnt;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 1;
        while (!resp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check_eq({e.tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check_eq({e.tag, ".latency"}, lat, e.lat);
        check_eq({e.tag, ".rdata"}, resp_rdata, e.rdata);
        check_eq({e.tag, ".err"}, {31'd0, resp_err}, {31'd0, e.err});
        // Hold off the consumer while a competing request is offered.
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h0;
            req_wdata = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            check_eq({e.tag, ".stall_valid"}, {31'd0, resp_valid}, 32'd1);
            check_eq({e.tag, ".stall_rdata"}, resp_rdata, e.rdata);
            check_eq({e.tag, ".stall_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq({e.tag, ".we_pulses"}, we_cnt - we0, e.we_pulses);
        check_eq({e.tag, ".resp_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        rst_n        = 1'b1;
        fill         = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst.resp_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst.resp_rdata", resp_rdata, 32'd0);
        check_eq("rst.mem_we", {31'd0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        fill  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req("sb8", 1'b1, 2'b00, 1'b0, 32'd8, 32'h00000012, 32'h0, 1'b0, 3, 1, 0);
        check_eq("mem8", ram_word(8), 32'hAAAAAA12);
        do_req("lb9s", 1'b0, 2'b00, 1'b0, 32'd9, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 0);
        do_req("lb9u", 1'b0, 2'b00, 1'b1, 32'd9, 32'h0, 32'h000000AA, 1'b0, 2, 0, 0);
        do_req("lb8s", 1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 32'h00000012, 1'b0, 2, 0, 0);
        do_req("sh10", 1'b1, 2'b01, 1'b0, 32'd10, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 0);
        do_req("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'hBEEFAA12, 1'b0, 2, 0, 5);
        check_eq("rogue_store", ram_word(0), 32'hAAAAAAAA);
`ifdef LSU_ALIGN_CHECK_EN
        do_req("lw9", 1'b0, 2'b10, 1'b0, 32'd9, 32'h0, 32'h00000000, 1'b1, 1, 0, 0);
        do_req("sw9", 1'b1, 2'b10, 1'b0, 32'd9, 32'h55555555, 32'h0, 1'b1, 1, 0, 0);
        do_req("lh11", 1'b0, 2'b01, 1'b0, 32'd11, 32'h0, 32'h00000000, 1'b1, 1, 0, 0);
`else
        do_req("lw9", 1'b0, 2'b10, 1'b0, 32'd9, 32'h0, 32'hAABEEFAA, 1'b0, 2, 0, 0);
        do_req("lh11u", 1'b0, 2'b01, 1'b1, 32'd11, 32'h0, 32'h0000AABE, 1'b0, 2, 0, 0);
`endif
        do_req("lh10s", 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 0);
        do_req("lh10u", 1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 0);
        do_req("sw32", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1, 0);
        do_req("lw32", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 2, 0, 0);
        do_req("lh34s", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00001122, 1'b0, 2, 0, 0);
        do_req("rsvd_ld", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b1, 1, 0, 0);
        do_req("rsvd_st", 1'b1, 2'b11, 1'b0, 32'h40, 32'h77777777, 32'h0, 1'b1, 1, 0, 0);
        check_eq("rsvd_mem", ram_word(32'h40), 32'hAAAAAAAA);

        // Reset during the read phase of a byte store aborts without a write.
        we0          = we_cnt;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd16;
        req_wdata    = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("abort.in_read", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort.req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("abort.mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort.we_pulses", we_cnt - we0, 32'd0);
        check_eq("abort.mem16", ram_word(16), 32'hAAAAAAAA);
        check_eq("abort.idle", {31'd0, req_ready}, 32'd1);
        check_eq("abort.no_resp", {31'd0, resp_valid}, 32'd0);

        do_req("post_rst", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'hBEEFAA12, 1'b0, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
